sync_fifo_param: RTL

Parametrised single-clock synchronous FIFO. It generalises the team's 8-deep byte FIFO to arbitrary width and power-of-two depth. It adds true full at DEPTH entries, programmable almost-full/almost-empty flags, an occupancy count, overflow/underflow error pulses, and an optional first-word-fall-through (FWFT) read mode. It sits between producer/consumer stages in the same clock domain and is the drop-in buffer for new datapaths.

---
 rtl/sync_fifo_param.sv | 112 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock synchronous FIFO with parameterised width and
// power-of-two depth. It provides full/empty/almost flags decoded from the
// occupancy count, overflow/underflow error pulses, and either a registered
// read (FWFT=0) or a first-word-fall-through head view (FWFT=1).
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   data_in      write data
//   wr_enable    write request; ignored while full
//   rd_enable    read request (pop of the head in FWFT mode); ignored while empty
//   data_out     read data (registered, or the live head in FWFT mode)
//   rd_valid     standard: data_out updated this cycle; FWFT: head is valid
//   full, empty, almost_full, almost_empty   decoded from count
//   count        occupancy, 0..DEPTH
//   overflow     one-cycle pulse after a write attempted while full
//   underflow    one-cycle pulse after a read attempted while empty
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    wr_enable,
    input  logic                    rd_enable,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if (DATA_WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
            AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
            AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_params
            $error("sync_fifo_param: illegal DEPTH or threshold parameters");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come straight from the registered count, so they describe the
    // state left by the previous edge.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AFULL_THRESH));
    assign almost_empty = (count <= CW'(AEMPTY_THRESH));

    // Acceptance uses pre-edge flags: a full FIFO still accepts a read, an
    // empty one still accepts a write, but never the other half.
    assign wr_ok = wr_enable && !full;
    assign rd_ok = rd_enable && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_enable && full;
            underflow <= rd_enable && empty;
            if (wr_ok) wptr <= wptr + AW'(1);
            if (rd_ok) rptr <= rptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not cleared by reset; only the write is suppressed.
    always_ff @(posedge clock) begin
        if (!reset && wr_ok) mem[wptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head is exposed directly; zero when nothing is stored.
            assign data_out = empty ? '0 : mem[rptr];
            assign rd_valid = !empty;
        end else begin : g_std
            always_ff @(posedge clock) begin
                if (reset) begin
                    data_out <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_ok;
                    if (rd_ok) data_out <= mem[rptr];
                end
            end
        end
    endgenerate

endmodule
